// File: rtl/vx_barrier_ctrl_pkg.sv
// vx_barrier_ctrl_pkg: shared widths and record types for the barrier controller.
package vx_barrier_ctrl_pkg;
    localparam int NUM_WARPS    = 4;
    localparam int NUM_BARRIERS = 4;
    localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;
    typedef struct packed {
        logic                 active;
        logic [NW_BITS-1:0]   size_m1;
        logic [NW_BITS:0]     count;
        logic [NUM_WARPS-1:0] wmask;
    } barrier_entry_t;
    typedef struct packed {
        logic [NW_BITS-1:0] wid;
        logic [NB_BITS-1:0] id;
        logic [NW_BITS-1:0] size_m1;
    } bar_req_t;
endpackage

// File: rtl/vx_barrier_ctrl_if.sv
// vx_barrier_ctrl_if: arrival request, stall mask and release handshake between warp control and scheduler.
interface vx_barrier_ctrl_if;
    import vx_barrier_ctrl_pkg::*;
    logic                 bar_req_valid;
    logic                 bar_req_ready;
    logic [NW_BITS-1:0]   bar_req_wid;
    logic [NB_BITS-1:0]   bar_req_id;
    logic [NW_BITS-1:0]   bar_req_size_m1;
    logic [NUM_WARPS-1:0] stalled_wmask;
    logic                 rel_valid;
    logic                 rel_ready;
    logic [NUM_WARPS-1:0] rel_wmask;
    logic [NB_BITS-1:0]   rel_id;
    logic                 dup_err;
    modport master (
        output bar_req_valid, bar_req_wid, bar_req_id, bar_req_size_m1, rel_ready,
        input  bar_req_ready, stalled_wmask, rel_valid, rel_wmask, rel_id, dup_err
    );
    modport slave (
        input  bar_req_valid, bar_req_wid, bar_req_id, bar_req_size_m1, rel_ready,
        output bar_req_ready, stalled_wmask, rel_valid, rel_wmask, rel_id, dup_err
    );
endinterface

// File: rtl/vx_barrier_entry.sv
// vx_barrier_entry: one barrier's arrival tracking; flags the arrival that completes the barrier.
module vx_barrier_entry
    import vx_barrier_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arr_i,
    input  bar_req_t             req_i,
    output logic [NUM_WARPS-1:0] wmask_o,
    output logic [NUM_WARPS-1:0] rel_wmask_o,
    output logic                 hit_o,
    output logic                 dup_o
);
    barrier_entry_t       entry_q, entry_d;
    logic [NUM_WARPS-1:0] onehot;
    logic [NW_BITS-1:0]   size_m1;
    logic [NW_BITS:0]     count_new;
    // the first arrival supplies the size; later arrivals' size fields are ignored
    always_comb begin
        onehot      = NUM_WARPS'(1) << req_i.wid;
        size_m1     = entry_q.active ? entry_q.size_m1 : req_i.size_m1;
        count_new   = entry_q.count + 1'b1;
        dup_o       = arr_i && entry_q.wmask[req_i.wid];
        hit_o       = arr_i && !dup_o && (count_new == (NW_BITS+1)'(size_m1) + 1'b1);
        rel_wmask_o = entry_q.wmask | onehot;
        wmask_o     = entry_q.wmask;
        entry_d     = entry_q;
        if (hit_o) begin
            entry_d = '0;
        end else if (arr_i && !dup_o) begin
            entry_d.active  = 1'b1;
            entry_d.size_m1 = size_m1;
            entry_d.count   = count_new;
            entry_d.wmask   = entry_q.wmask | onehot;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) entry_q <= '0;
        else        entry_q <= entry_d;
    end
endmodule

// File: rtl/vx_barrier_ctrl.sv
// vx_barrier_ctrl: per-core barrier controller; decodes arrivals to entries and registers one release at a time.
module vx_barrier_ctrl
    import vx_barrier_ctrl_pkg::*;
(
    input logic              clk,
    input logic              reset,
    vx_barrier_ctrl_if.slave bar
);
    bar_req_t             req;
    logic                 ready, accept;
    logic [NUM_BARRIERS-1:0] hit, dup;
    logic [NUM_WARPS-1:0] wmask [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] rel_mask [NUM_BARRIERS];
    logic [NUM_WARPS-1:0] stalled, rel_wmask_q, rel_wmask_d;
    logic [NB_BITS-1:0]   rel_id_q, rel_id_d;
    logic                 rel_valid_q, rel_valid_d, dup_q;
    assign req    = '{wid: bar.bar_req_wid, id: bar.bar_req_id, size_m1: bar.bar_req_size_m1};
    assign ready  = !(rel_valid_q && !bar.rel_ready);
    assign accept = bar.bar_req_valid && ready;
    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_entry
        vx_barrier_entry u_entry (
            .clk         (clk),
            .reset       (reset),
            .arr_i       (accept && req.id == NB_BITS'(g)),
            .req_i       (req),
            .wmask_o     (wmask[g]),
            .rel_wmask_o (rel_mask[g]),
            .hit_o       (hit[g]),
            .dup_o       (dup[g])
        );
    end
    // a new release may load in the same cycle the previous one is consumed
    always_comb begin
        stalled = '0;
        for (int i = 0; i < NUM_BARRIERS; i++) stalled |= wmask[i];
        rel_valid_d = |hit || (rel_valid_q && !bar.rel_ready);
        rel_wmask_d = |hit ? rel_mask[req.id] : (bar.rel_ready ? '0 : rel_wmask_q);
        rel_id_d    = |hit ? req.id : (bar.rel_ready ? '0 : rel_id_q);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            rel_valid_q <= 1'b0;
            rel_wmask_q <= '0;
            rel_id_q    <= '0;
            dup_q       <= 1'b0;
        end else begin
            rel_valid_q <= rel_valid_d;
            rel_wmask_q <= rel_wmask_d;
            rel_id_q    <= rel_id_d;
            dup_q       <= |dup;
        end
    end
    assign bar.bar_req_ready = ready;
    assign bar.stalled_wmask = stalled;
    assign bar.rel_valid     = rel_valid_q;
    assign bar.rel_wmask     = rel_wmask_q;
    assign bar.rel_id        = rel_id_q;
    assign bar.dup_err       = dup_q;
endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// tb_vx_barrier_ctrl: vector table, directed reset sequence and randomized model comparison for vx_barrier_ctrl.
module tb_vx_barrier_ctrl;
    import vx_barrier_ctrl_pkg::*;
    typedef logic [NUM_WARPS-1:0] wmask_t;
    typedef struct {
        logic v; int wid; int id; int sz; logic rr;
        wmask_t stall; logic rv; wmask_t rm; int rid; logic dup; logic rdy;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    int wq[NUM_BARRIERS][$];
    int need[NUM_BARRIERS];
    logic m_rv, m_dup;
    wmask_t m_rm;
    int m_rid;
    vx_barrier_ctrl_if bif();
    vx_barrier_ctrl dut (.clk(clk), .reset(reset), .bar(bif));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input wmask_t stall, input logic rv, input wmask_t rm,
                             input int rid, input logic dup, input logic rdy);
        chk({tag, " stalled_wmask"}, 32'(bif.stalled_wmask), 32'(stall));
        chk({tag, " rel_valid"}, 32'(bif.rel_valid), 32'(rv));
        chk({tag, " rel_wmask"}, 32'(bif.rel_wmask), 32'(rm));
        chk({tag, " rel_id"}, 32'(bif.rel_id), 32'(rid));
        chk({tag, " dup_err"}, 32'(bif.dup_err), 32'(dup));
        chk({tag, " bar_req_ready"}, 32'(bif.bar_req_ready), 32'(rdy));
    endtask

    task automatic drive(input logic v, input int w, input int id, input int sz, input logic rr);
        bif.bar_req_valid   = v;
        bif.bar_req_wid     = NW_BITS'(w);
        bif.bar_req_id      = NB_BITS'(id);
        bif.bar_req_size_m1 = NW_BITS'(sz);
        bif.rel_ready       = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic v, input int w, input int id, input int sz, input logic rr,
                       input wmask_t stall, input logic rv, input wmask_t rm, input int rid,
                       input logic dup, input logic rdy);
        vec_t e;
        e = '{v, w, id, sz, rr, stall, rv, rm, rid, dup, rdy};
        vecs.push_back(e);
    endtask

    initial begin
        //   v  wid id sz rr  stall    rv rm       rid dup rdy
        add(1, 0, 1, 3, 1, 4'b0001, 0, 4'b0000, 0, 0, 1);
        add(1, 1, 1, 3, 1, 4'b0011, 0, 4'b0000, 0, 0, 1);
        add(1, 2, 1, 3, 1, 4'b0111, 0, 4'b0000, 0, 0, 1);
        add(1, 3, 1, 3, 1, 4'b0000, 1, 4'b1111, 1, 0, 1);
        add(1, 2, 0, 0, 1, 4'b0000, 1, 4'b0100, 0, 0, 1);
        add(0, 0, 0, 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(1, 1, 2, 2, 1, 4'b0010, 0, 4'b0000, 0, 0, 1);
        add(1, 1, 2, 2, 1, 4'b0010, 0, 4'b0000, 0, 1, 1);
        add(0, 0, 0, 0, 1, 4'b0010, 0, 4'b0000, 0, 0, 1);
        add(1, 0, 2, 0, 1, 4'b0011, 0, 4'b0000, 0, 0, 1);
        add(1, 3, 2, 0, 1, 4'b0000, 1, 4'b1011, 2, 0, 1);
        add(0, 0, 0, 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(1, 0, 0, 1, 1, 4'b0001, 0, 4'b0000, 0, 0, 1);
        add(1, 2, 3, 1, 1, 4'b0101, 0, 4'b0000, 0, 0, 1);
        add(1, 1, 0, 1, 1, 4'b0100, 1, 4'b0011, 0, 0, 1);
        add(1, 3, 3, 1, 1, 4'b0000, 1, 4'b1100, 3, 0, 1);
        add(0, 0, 0, 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(1, 0, 1, 0, 0, 4'b0000, 1, 4'b0001, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 4'b0000, 1, 4'b0001, 1, 0, 0);
        add(0, 0, 0, 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 1);

        reset = 1'b0;
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        reset = 1'b1;
        drive(0, 0, 0, 0, 1);
        check_all("reset", '0, 0, '0, 0, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].wid, vecs[i].id, vecs[i].sz, vecs[i].rr);
            check_all($sformatf("vec%0d", i), vecs[i].stall, vecs[i].rv, vecs[i].rm,
                      vecs[i].rid, vecs[i].dup, vecs[i].rdy);
        end

        // reset while warps 0 and 1 wait at barrier 0 must drop them silently
        drive(1, 0, 0, 3, 1);
        drive(1, 1, 0, 3, 1);
        chk("pre_reset stalled_wmask", 32'(bif.stalled_wmask), 32'h3);
        reset = 1'b0;
        drive(0, 0, 0, 0, 1);
        chk("mid_reset stalled_wmask", 32'(bif.stalled_wmask), 32'h0);
        chk("mid_reset rel_valid", 32'(bif.rel_valid), 32'h0);
        reset = 1'b1;
        drive(1, 2, 0, 1, 1);
        check_all("post_reset1", 4'b0100, 0, '0, 0, 0, 1);
        drive(1, 3, 0, 1, 1);
        check_all("post_reset2", 4'b0000, 1, 4'b1100, 0, 0, 1);

        reset = 1'b0;
        drive(0, 0, 0, 0, 1);
        reset = 1'b1;
        m_rv = 0; m_rm = '0; m_rid = 0; m_dup = 0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            wq[b].delete();
            need[b] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            logic v, rr, rdy, found;
            int w, bid, sz;
            wmask_t stall;
            v   = $urandom_range(0, 99) < 60;
            rr  = $urandom_range(0, 99) < 70;
            w   = $urandom_range(0, NUM_WARPS - 1);
            bid = $urandom_range(0, NUM_BARRIERS - 1);
            sz  = $urandom_range(0, NUM_WARPS - 1);
            rdy = !(m_rv && !rr);
            m_dup = 0;
            if (m_rv && rr) begin
                m_rv = 0; m_rm = '0; m_rid = 0;
            end
            if (v && rdy) begin
                found = 0;
                for (int k = 0; k < wq[bid].size(); k++) if (wq[bid][k] == w) found = 1;
                if (found) m_dup = 1;
                else begin
                    if (wq[bid].size() == 0) need[bid] = sz + 1;
                    if (wq[bid].size() + 1 == need[bid]) begin
                        m_rv  = 1;
                        m_rid = bid;
                        m_rm  = wmask_t'(1) << w;
                        for (int k = 0; k < wq[bid].size(); k++) m_rm |= wmask_t'(1) << wq[bid][k];
                        wq[bid].delete();
                    end else wq[bid].push_back(w);
                end
            end
            drive(v, w, bid, sz, rr);
            stall = '0;
            for (int b = 0; b < NUM_BARRIERS; b++)
                for (int k = 0; k < wq[b].size(); k++) stall |= wmask_t'(1) << wq[b][k];
            check_all($sformatf("rand%0d", c), stall, m_rv, m_rm, m_rid, m_dup, !(m_rv && !rr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vx_barrier_ctrl.md
# vx_barrier_ctrl

Per-core barrier controller sitting between the GPU unit's warp-control output and the warp scheduler. Tracks arrivals of warps at each hardware barrier, reports a mask of warps that must be held off the issue stage, and emits a single release event when the last expected warp arrives. It sequences the barrier portion of the warp-control path; TMC, WSPAWN and SPLIT traffic bypasses it.

## Interface
- NUM_WARPS, 4: warps per core; NW_BITS = max(1, clog2(NUM_WARPS)).
- NUM_BARRIERS, 4: hardware barriers; NB_BITS = max(1, clog2(NUM_BARRIERS)).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low (asserted when 0).
- bar_req_valid  in  1  barrier arrival request.
- bar_req_ready  out  1  request accepted when valid && ready.
- bar_req_wid  in  NW_BITS  arriving warp.
- bar_req_id  in  NB_BITS  barrier id.
- bar_req_size_m1  in  NW_BITS  number of participating warps minus one.
- stalled_wmask  out  NUM_WARPS  warps currently waiting at any barrier.
- rel_valid  out  1  release event pending.
- rel_ready  in  1  scheduler consumes release when valid && ready.
- rel_wmask  out  NUM_WARPS  warps to resume.
- rel_id  out  NB_BITS  barrier being released.
- dup_err  out  1  one-cycle pulse: warp already waiting at that barrier re-arrived.

## Operation
- Per-barrier state: active flag, latched size_m1, arrival count (NW_BITS+1 bits), waiting mask (NUM_WARPS).
- Accepted request on idle barrier: latch size_m1; size from later arrivals ignored.
- Arrival, count_new = count+1; if count_new == latched size_m1+1 (size_m1 on first arrival): release — load rel_wmask = waiting | onehot(wid), rel_id = id, rel_valid=1; clear entry (active=0, count=0, mask=0).
- Otherwise: set waiting bit, count = count_new, active=1.
- size_m1 == 0: immediate release of the arriving warp alone; it never appears in stalled_wmask.
- Arrival of a warp whose bit is already set in that barrier's mask: no state change, dup_err pulses next cycle.
- stalled_wmask = OR of all barriers' waiting masks (combinational from registers).
- Distinct barriers are independent; a warp may not wait at two barriers (it is stalled), not checked.
- bar_req_ready = !(rel_valid && !rel_ready): new arrivals blocked only while a release is stuck. A release accepted and a new request accepted in the same cycle are both legal; the new request may produce the next release.
- Reset: all entries cleared; stalled_wmask=0, rel_valid=0, rel_wmask=0, rel_id=0, dup_err=0, bar_req_ready=1 (after reset deassertion). Reset mid-barrier discards waiting warps without a release.

## Timing
- Request accepted at edge N: stalled_wmask bit visible from cycle N+1.
- Releasing arrival accepted at edge N: rel_valid high from N+1; the released warps' stalled_wmask bits clear in the same cycle N+1 (no overlap with rel_valid).
- rel_valid/rel_wmask/rel_id held stable until rel_ready; cleared the edge after handshake unless a new release loads.
- Back-to-back releases: one per cycle when rel_ready is held high.
- dup_err: exactly one cycle, at N+1.

## Structure
- Shared package: NW_BITS/NB_BITS derivation, typedef barrier_entry_t {active, size_m1, count, wmask}, typedef bar_req_t {wid, id, size_m1}.
- One sub-module natural: vx_barrier_entry (one instance per barrier) holding the entry register, arrival/match logic, and release-hit output; top level does id decode, mask OR-reduction, and release output register.

## Test plan
- NUM_WARPS=4: size_m1=3, barrier 1, warps 0,1,2 arrive on consecutive cycles -> stalled_wmask 0001,0011,0111; warp 3 arrives -> rel_valid=1, rel_wmask=1111, rel_id=1, stalled_wmask=0000.
- size_m1=0, warp 2 at barrier 0 -> rel_wmask=0100 next cycle, stalled_wmask never nonzero.
- Warp 1 arrives twice at barrier 2 (size_m1=2) -> dup_err pulses once, count stays 1, stalled_wmask=0010.
- rel_ready held 0 for 5 cycles during a release -> bar_req_ready=0, outputs stable; rel_ready=1 -> release drops next cycle, bar_req_ready=1.
- Two barriers interleaved (0: size_m1=1 warps 0,1; 3: size_m1=1 warps 2,3) -> two releases, masks 0011 id 0 then 1100 id 3.
- reset=0 while warps 0,1 waiting -> next cycle stalled_wmask=0000, rel_valid=0; subsequent barrier operates from empty state.
